// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - shared ALU codes, opcodes, funct values, state encoding and decode classes
package multicycle_control_unit_pkg;

   localparam logic [3:0] ALUADD = 4'd0;
   localparam logic [3:0] ALUSUB = 4'd1;
   localparam logic [3:0] ALUAND = 4'd2;
   localparam logic [3:0] ALUNOR = 4'd3;
   localparam logic [3:0] ALUXOR = 4'd4;
   localparam logic [3:0] ALUSFL = 4'd5;
   localparam logic [3:0] ALUSFR = 4'd6;
   localparam logic [3:0] ALUSLT = 4'd7;
   localparam logic [3:0] ALUMUL = 4'd8;
   localparam logic [3:0] ALUDIV = 4'd9;
   localparam logic [3:0] ALUSNQ = 4'd10;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_HALT  = 6'd63;

   localparam logic [5:0] F_SFL = 6'd0;
   localparam logic [5:0] F_SFR = 6'd2;
   localparam logic [5:0] F_MUL = 6'd24;
   localparam logic [5:0] F_DIV = 6'd26;
   localparam logic [5:0] F_ADD = 6'd32;
   localparam logic [5:0] F_SUB = 6'd34;
   localparam logic [5:0] F_AND = 6'd36;
   localparam logic [5:0] F_XOR = 6'd38;
   localparam logic [5:0] F_NOR = 6'd39;
   localparam logic [5:0] F_SLT = 6'd42;

   localparam logic [2:0] S_FETCH     = 3'd0;
   localparam logic [2:0] S_DECODE    = 3'd1;
   localparam logic [2:0] S_EXECUTE   = 3'd2;
   localparam logic [2:0] S_MEMORY    = 3'd3;
   localparam logic [2:0] S_WRITEBACK = 3'd4;
   localparam logic [2:0] S_HALT      = 3'd5;

   typedef enum logic [2:0] {
      CLS_RTYPE, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_HALT
   } instr_class_t;

endpackage

// File: rtl/multicycle_control_unit_instruction_decoder.sv
// rtl/multicycle_control_unit_instruction_decoder.sv - opcode/funct to class, ALU code and legal flag
// MULDIV_EN makes funct MUL/DIV legal R-type operations.
import multicycle_control_unit_pkg::*;

module instruction_decoder (
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   output instr_class_t iclass,
   output logic [3:0]   alu_code,
   output logic         legal
);

   always_comb begin
      iclass   = CLS_HALT;
      alu_code = ALUADD;
      legal    = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            iclass = CLS_RTYPE;
            case (funct)
               F_ADD:   alu_code = ALUADD;
               F_SUB:   alu_code = ALUSUB;
               F_AND:   alu_code = ALUAND;
               F_NOR:   alu_code = ALUNOR;
               F_XOR:   alu_code = ALUXOR;
               F_SFL:   alu_code = ALUSFL;
               F_SFR:   alu_code = ALUSFR;
               F_SLT:   alu_code = ALUSLT;
`ifdef MULDIV_EN
               F_MUL:   alu_code = ALUMUL;
               F_DIV:   alu_code = ALUDIV;
`endif
               default: legal = 1'b0;
            endcase
         end
         OP_ADDI: iclass = CLS_ADDI;
         OP_LW:   iclass = CLS_LW;
         OP_SW:   iclass = CLS_SW;
         OP_BEQ: begin
            iclass   = CLS_BEQ;
            alu_code = ALUSUB;
         end
         OP_BNE: begin
            iclass   = CLS_BNE;
            alu_code = ALUSUB;
         end
         OP_J:    iclass = CLS_J;
         // OP_HALT and every unassigned opcode stop the machine
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer
// MULDIV_EN enables MUL/DIV with a DIV_CYCLES-long EXECUTE hold.
import multicycle_control_unit_pkg::*;

module multicycle_control_unit #(
   parameter int DIV_CYCLES = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [0:31] instruction,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        alu_zero,
   output logic        imem_req,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic        ir_write,
   output logic [0:3]  alu_operation,
   output logic        alu_src_imm,
   output logic        pc_write,
   output logic        pc_branch,
   output logic        pc_jump,
   output logic        reg_write,
   output logic        reg_dst_rd,
   output logic        mem_to_reg,
   output logic        halted
);

   if (DIV_CYCLES < 1 || DIV_CYCLES > 255) begin : g_bad_div_cycles
      $error("DIV_CYCLES must be within 1..255");
   end

   logic [2:0]   state, state_next;
   logic [5:0]   opcode_q, funct_q;
   instr_class_t iclass;
   logic [3:0]   dec_alu;
   logic         legal;
   logic         exec_hold;
   logic         take_branch;
   logic         unused_fields;

   assign unused_fields = ^instruction[6:25];

   instruction_decoder u_dec (
      .opcode   (opcode_q),
      .funct    (funct_q),
      .iclass   (iclass),
      .alu_code (dec_alu),
      .legal    (legal)
   );

   // opcode/funct are captured with the IR so DECODE never depends on the bus holding its value
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= S_FETCH;
         opcode_q <= '0;
         funct_q  <= '0;
      end else begin
         state <= state_next;
         if (state == S_FETCH && imem_ready) begin
            opcode_q <= instruction[0:5];
            funct_q  <= instruction[26:31];
         end
      end
   end

`ifdef MULDIV_EN
   logic [7:0] exec_cnt;
   logic       dec_multi;

   assign dec_multi = (iclass == CLS_RTYPE) && (dec_alu == ALUMUL || dec_alu == ALUDIV);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         exec_cnt <= '0;
      end else if (state == S_DECODE) begin
         exec_cnt <= dec_multi ? 8'(DIV_CYCLES - 1) : 8'd0;
      end else if (state == S_EXECUTE && exec_cnt != 8'd0) begin
         exec_cnt <= exec_cnt - 8'd1;
      end
   end

   assign exec_hold = (exec_cnt != 8'd0);
`else
   assign exec_hold = 1'b0;
`endif

   assign take_branch = (iclass == CLS_BEQ && alu_zero) || (iclass == CLS_BNE && !alu_zero);

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:     if (imem_ready) state_next = S_DECODE;
         S_DECODE: begin
            if (!legal)                 state_next = S_HALT;
            else if (iclass == CLS_J)   state_next = S_FETCH;
            else                        state_next = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (!exec_hold) begin
               case (iclass)
                  CLS_RTYPE, CLS_ADDI: state_next = S_WRITEBACK;
                  CLS_LW, CLS_SW:      state_next = S_MEMORY;
                  CLS_BEQ, CLS_BNE:    state_next = S_FETCH;
                  default:             state_next = S_HALT;
               endcase
            end
         end
         S_MEMORY:    if (dmem_ready) state_next = (iclass == CLS_LW) ? S_WRITEBACK : S_FETCH;
         S_WRITEBACK: state_next = S_FETCH;
         default:     state_next = S_HALT;
      endcase
   end

   // gating on reset makes requests drop combinationally, before any clock edge
   always_comb begin
      imem_req      = 1'b0;
      dmem_read     = 1'b0;
      dmem_write    = 1'b0;
      ir_write      = 1'b0;
      alu_operation = ALUADD;
      alu_src_imm   = 1'b0;
      pc_write      = 1'b0;
      pc_branch     = 1'b0;
      pc_jump       = 1'b0;
      reg_write     = 1'b0;
      reg_dst_rd    = 1'b0;
      mem_to_reg    = 1'b0;
      halted        = 1'b0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_write = imem_ready;
               pc_write = imem_ready;
            end
            S_DECODE: begin
               if (legal && iclass == CLS_J) begin
                  pc_write = 1'b1;
                  pc_jump  = 1'b1;
               end
            end
            S_EXECUTE: begin
               alu_operation = dec_alu;
               alu_src_imm   = (iclass == CLS_ADDI) || (iclass == CLS_LW) || (iclass == CLS_SW);
               pc_write      = take_branch;
               pc_branch     = take_branch;
            end
            S_MEMORY: begin
               dmem_read  = (iclass == CLS_LW);
               dmem_write = (iclass == CLS_SW);
            end
            S_WRITEBACK: begin
               reg_write  = 1'b1;
               reg_dst_rd = (iclass == CLS_RTYPE);
               mem_to_reg = (iclass == CLS_LW);
            end
            S_HALT:  halted = 1'b1;
            default: halted = 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed scoreboard bench for multicycle_control_unit
import multicycle_control_unit_pkg::*;

module tb_multicycle_control_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [0:31] instruction = '0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        alu_zero = 1'b0;
   logic        imem_req, dmem_read, dmem_write, ir_write;
   logic [0:3]  alu_operation;
   logic        alu_src_imm, pc_write, pc_branch, pc_jump;
   logic        reg_write, reg_dst_rd, mem_to_reg, halted;

   multicycle_control_unit #(.DIV_CYCLES(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .instruction   (instruction),
      .imem_ready    (imem_ready),
      .dmem_ready    (dmem_ready),
      .alu_zero      (alu_zero),
      .imem_req      (imem_req),
      .dmem_read     (dmem_read),
      .dmem_write    (dmem_write),
      .ir_write      (ir_write),
      .alu_operation (alu_operation),
      .alu_src_imm   (alu_src_imm),
      .pc_write      (pc_write),
      .pc_branch     (pc_branch),
      .pc_jump       (pc_jump),
      .reg_write     (reg_write),
      .reg_dst_rd    (reg_dst_rd),
      .mem_to_reg    (mem_to_reg),
      .halted        (halted)
   );

   always #5 clock = ~clock;

   localparam logic [15:0] IREQ = 16'h8000, DRD = 16'h4000, DWR = 16'h2000, IRW = 16'h1000;
   localparam logic [15:0] IMM  = 16'h0080, PCW = 16'h0040, PCB = 16'h0020, PCJ = 16'h0010;
   localparam logic [15:0] RW   = 16'h0008, RD  = 16'h0004, M2R = 16'h0002, HLT = 16'h0001;
   localparam logic [15:0] FDONE = IREQ | IRW | PCW;

   typedef struct {
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic [15:0] got;

   assign got = {imem_req, dmem_read, dmem_write, ir_write, alu_operation, alu_src_imm,
                 pc_write, pc_branch, pc_jump, reg_write, reg_dst_rd, mem_to_reg, halted};

   function automatic logic [15:0] alu(input logic [3:0] c);
      return {4'b0000, c, 8'h00};
   endfunction

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
      return {op, 20'h00000, fn};
   endfunction

   always @(negedge clock) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (got !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
         end
      end
   end

   task automatic cyc(input string nm, input logic rst, input logic [31:0] ins,
                      input logic ir, input logic dr, input logic z, input logic [15:0] exp);
      reset       = rst;
      instruction = ins;
      imem_ready  = ir;
      dmem_ready  = dr;
      alu_zero    = z;
      sb.push_back('{exp: exp, name: nm});
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [31:0] i;
      @(posedge clock);
      #1;

      i = mk(6'd0, 6'd34);
      cyc("reset_hold",   1, i, 1, 1, 1, alu(ALUADD));
      cyc("first_fetch",  0, i, 0, 0, 0, IREQ);
      cyc("r_fetch",      0, i, 1, 0, 0, FDONE);
      cyc("r_decode",     0, i, 1, 1, 0, alu(ALUADD));
      cyc("r_exec_sub",   0, i, 0, 0, 0, alu(ALUSUB));
      cyc("r_writeback",  0, i, 0, 0, 0, RW | RD);

      i = mk(6'd8, 6'd0);
      cyc("addi_fetch",   0, i, 1, 0, 0, FDONE);
      cyc("addi_decode",  0, i, 0, 0, 0, alu(ALUADD));
      cyc("addi_exec",    0, i, 0, 0, 0, alu(ALUADD) | IMM);
      cyc("addi_wb",      0, i, 0, 0, 0, RW);

      i = mk(6'd35, 6'd0);
      cyc("lw_fetch",     0, i, 1, 0, 0, FDONE);
      cyc("lw_decode",    0, i, 0, 0, 0, alu(ALUADD));
      cyc("lw_exec",      0, i, 0, 1, 0, alu(ALUADD) | IMM);
      for (int k = 0; k < 3; k++) cyc("lw_mem_wait", 0, i, 0, 0, 0, DRD);
      cyc("lw_mem_done",  0, i, 0, 1, 0, DRD);
      cyc("lw_wb",        0, i, 0, 0, 0, RW | M2R);

      i = mk(6'd43, 6'd0);
      cyc("sw_fetch",     0, i, 1, 0, 0, FDONE);
      cyc("sw_decode",    0, i, 0, 0, 0, alu(ALUADD));
      cyc("sw_exec",      0, i, 0, 0, 0, alu(ALUADD) | IMM);
      cyc("sw_mem",       0, i, 0, 1, 0, DWR);

      i = mk(6'd4, 6'd0);
      cyc("beq_fetch",    0, i, 1, 0, 1, FDONE);
      cyc("beq_decode",   0, i, 0, 0, 1, alu(ALUADD));
      cyc("beq_taken",    0, i, 0, 0, 1, alu(ALUSUB) | PCW | PCB);
      cyc("beq_fetch2",   0, i, 1, 0, 0, FDONE);
      cyc("beq_decode2",  0, i, 0, 0, 0, alu(ALUADD));
      cyc("beq_not",      0, i, 0, 0, 0, alu(ALUSUB));

      i = mk(6'd5, 6'd0);
      cyc("bne_fetch",    0, i, 1, 0, 0, FDONE);
      cyc("bne_decode",   0, i, 0, 0, 0, alu(ALUADD));
      cyc("bne_taken",    0, i, 0, 0, 0, alu(ALUSUB) | PCW | PCB);

      i = mk(6'd2, 6'd0);
      cyc("j_fetch",      0, i, 1, 0, 0, FDONE);
      cyc("j_decode",     0, i, 0, 0, 0, PCW | PCJ);

      i = mk(6'd0, 6'd1);
      cyc("badf_fetch",   0, i, 1, 0, 0, FDONE);
      cyc("badf_decode",  0, i, 0, 0, 0, alu(ALUADD));
      cyc("badf_halt",    0, i, 1, 1, 0, HLT);
      cyc("badf_halt2",   0, i, 1, 1, 0, HLT);
      cyc("badf_reset",   1, i, 1, 1, 0, alu(ALUADD));

      i = mk(6'd0, 6'd26);
      cyc("div_fetch",    0, i, 1, 0, 0, FDONE);
      cyc("div_decode",   0, i, 0, 0, 0, alu(ALUADD));
`ifdef MULDIV_EN
      for (int k = 0; k < 8; k++) cyc("div_exec", 0, i, 0, 0, 0, alu(ALUDIV));
      cyc("div_wb",       0, i, 0, 0, 0, RW | RD);
`else
      cyc("div_halt",     0, i, 1, 0, 0, HLT);
      cyc("div_halt2",    0, i, 1, 0, 0, HLT);
`endif
      cyc("div_reset",    1, i, 0, 0, 0, alu(ALUADD));

      i = mk(6'd35, 6'd0);
      cyc("rlw_fetch",    0, i, 1, 0, 0, FDONE);
      cyc("rlw_decode",   0, i, 0, 0, 0, alu(ALUADD));
      cyc("rlw_exec",     0, i, 0, 0, 0, alu(ALUADD) | IMM);
      cyc("rlw_mem",      0, i, 0, 0, 0, DRD);
      cyc("mem_reset",    1, i, 0, 0, 0, alu(ALUADD));
      cyc("post_reset",   0, i, 0, 0, 0, IREQ);

      i = mk(6'd63, 6'd0);
      cyc("halt_fetch",   0, i, 1, 0, 0, FDONE);
      cyc("halt_decode",  0, i, 1, 0, 0, alu(ALUADD));
      for (int k = 0; k < 3; k++) cyc("halt_stays", 0, i, 1, 1, 0, HLT);
      cyc("halt_reset",   1, i, 1, 1, 0, alu(ALUADD));
      cyc("halt_refetch", 0, i, 0, 0, 0, IREQ);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clock);
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
